// File: rtl/scoreboard_register_file.sv
// Multi-port register file with a per-register pending-write scoreboard; reads combinational
// (optional same-cycle forwarding), busy/pend_cnt registered one edge after request; no backpressure.
module scoreboard_register_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR*SEL_W-1:0]    wsel,
    input  logic [NWR*DATA_W-1:0]   wdat,
    input  logic [NRD*SEL_W-1:0]    rsel,
    output logic [NRD*DATA_W-1:0]   rdat,
    output logic [NRD-1:0]          rbusy,
    input  logic                    rsv_en,
    input  logic [SEL_W-1:0]        rsv_sel,
    output logic                    rsv_ok,
    input  logic                    flush,
    output logic [NREGS-1:0]        busy,
    output logic [SEL_W:0]          pend_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  wr_hit;
    logic [NREGS-1:0]  busy_nxt;
    logic [SEL_W:0]    cnt_nxt;

    // Registers targeted by any enabled write this cycle (index 0 excluded).
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && (wsel[k*SEL_W +: SEL_W] != '0))
                wr_hit[wsel[k*SEL_W +: SEL_W]] = 1'b1;
        end
    end

    assign rsv_ok = rsv_en && !flush && !RST && !busy[rsv_sel];

    // A reservation set beats a write clear of the same register; flush beats everything.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (rsv_ok)
            busy_nxt[rsv_sel] = 1'b1;
        busy_nxt[0] = 1'b0;
        if (flush)
            busy_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + (SEL_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Later ports are applied last, so the highest-numbered port wins on a collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && (wsel[k*SEL_W +: SEL_W] != '0))
                    regs[wsel[k*SEL_W +: SEL_W]] <= wdat[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] val;
        logic              hit;
        rdat  = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            sel = rsel[j*SEL_W +: SEL_W];
            val = (sel == '0) ? '0 : regs[sel];
            hit = 1'b0;
            if ((BYPASS != 0) && !RST && (sel != '0)) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (wsel[k*SEL_W +: SEL_W] == sel)) begin
                        val = wdat[k*DATA_W +: DATA_W];
                        hit = 1'b1;
                    end
                end
            end
            rdat[j*DATA_W +: DATA_W] = val;
            rbusy[j] = busy[sel] && !hit;
        end
    end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 SHALL provide parameters, one per line:
  DATA_W, 32, register width in bits
  NREGS, 32, register count (power of two, >=2); SEL_W = clog2(NREGS)
  NRD, 2, read port count
  NWR, 2, write port count
  BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none
REQ-002 SHALL provide ports, one per line:
  CLK  in  1  clock; all state updates on rising edge
  RST  in  1  reset, synchronous, active-high
  wen  in  NWR  per-port write enable
  wsel  in  NWR*SEL_W  per-port write index, port k at [k*SEL_W +: SEL_W]
  wdat  in  NWR*DATA_W  per-port write data
  rsel  in  NRD*SEL_W  per-port read index
  rdat  out  NRD*DATA_W  per-port read data, combinational
  rbusy  out  NRD  per-port "read register has pending reservation"
  rsv_en  in  1  reserve request for destination rsv_sel
  rsv_sel  in  SEL_W  register to reserve
  rsv_ok  out  1  reservation accepted this cycle
  flush  in  1  drop all pending reservations
  busy  out  NREGS  pending-reservation bitmap
  pend_cnt  out  SEL_W+1  number of set busy bits
REQ-003 Reset SHALL be synchronous and active-high on RST, sampled on rising CLK; single clock domain.

Function
REQ-004 Register 0 SHALL read as 0 always; writes to 0 ignored; busy[0] always 0.
REQ-005 Write port k with wen[k]=1 and wsel!=0 SHALL update the register at rising CLK.
REQ-006 Same-index writes from multiple ports in one cycle: highest-numbered port wins.
REQ-007 BYPASS=1: rdat SHALL equal the winning same-cycle wdat when rsel matches an enabled write (index!=0); else stored value.
REQ-008 BYPASS=0: rdat SHALL be the stored value only; new data visible the cycle after the write edge.
REQ-009 rsv_ok SHALL be 1 iff rsv_en=1, flush=0, and busy[rsv_sel]=0; rsv_sel=0 gives rsv_ok=1 with no state change.
REQ-010 Accepted reservation SHALL set busy[rsv_sel] at next rising CLK.
REQ-011 Any enabled write to register r SHALL clear busy[r] at the same edge.
REQ-012 Same-cycle write-clear and accepted reservation of the same r: set wins (busy[r]=1 next cycle; reservation is for a later write).
REQ-013 flush=1 SHALL clear all busy bits at next edge and override any same-cycle set; register data unaffected, writes still performed.
REQ-014 rbusy[j] SHALL be busy[rsel_j]; with BYPASS=1 it SHALL be 0 when a same-cycle enabled write targets rsel_j.
REQ-015 pend_cnt SHALL equal the popcount of busy, registered and updated with busy (never combinational from inputs); max NREGS-1.
REQ-016 Writes to non-busy registers SHALL be legal and leave busy unchanged.

Reset
REQ-017 RST=1 at rising CLK SHALL zero all registers, busy, pend_cnt; RST overrides wen, rsv_en, flush in that cycle.
REQ-018 While RST=1, rsv_ok SHALL be 0; rdat reflects zeroed state from the cycle after the reset edge, no bypass during RST.
REQ-019 Reset mid-operation SHALL discard all pending reservations with no partial updates.

Verification
REQ-020 Reset then read all indices on both ports -> rdat=0, busy=0, pend_cnt=0.
REQ-021 wen=2'b11, wsel={5,5}, wdat={0xBBBB,0xAAAA}, rsel0=5, BYPASS=1 -> rdat0=0xBBBB same cycle; stored 0xBBBB next cycle.
REQ-022 Reserve r7 (rsv_ok=1), next cycle reserve r7 again -> rsv_ok=0; busy[7]=1, pend_cnt=1; write r7=0x1234 -> busy[7]=0, pend_cnt=0.
REQ-023 busy[3]=1; same cycle write r3 and reserve r3 -> rsv_ok=0 (busy); write r3 with busy[3]=0 plus reserve r3 -> busy[3]=1 next cycle.
REQ-024 Reserve r1,r2,r4 then flush with rsv_en on r9 -> busy=0, pend_cnt=0, rsv_ok=0, data intact.
REQ-025 Write r0=0xFFFF and reserve r0 -> rdat(r0)=0, busy[0]=0, pend_cnt unchanged.
